// File: rtl/rv32_mod_trap_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mod_trap_controller_if
// Description : Issue / redirect bundle shared by the instruction decoder and
//               the trap controller.
//               Decoder -> controller : instr_valid, pc, instr_imm0,
//                                        sys_jump_to_m, sys_ret_from_priv,
//                                        dec_error
//               Controller -> decoder : priviledge, in_trap_handler, busy
//               Controller -> fetch   : redirect_valid, redirect_pc
//               master = decoder/core side, slave = trap controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_mod_trap_controller_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic        instr_imm0;
  logic        sys_jump_to_m;
  logic        sys_ret_from_priv;
  logic        dec_error;
  logic [1:0]  priviledge;
  logic        in_trap_handler;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output instr_valid, pc, instr_imm0, sys_jump_to_m, sys_ret_from_priv, dec_error,
    input  priviledge, in_trap_handler, busy, redirect_valid, redirect_pc
  );

  modport slave (
    input  instr_valid, pc, instr_imm0, sys_jump_to_m, sys_ret_from_priv, dec_error,
    output priviledge, in_trap_handler, busy, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/rv32_mod_trap_controller.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mod_trap_controller
// Description : Privilege and trap sequencer for the rv32imc_ss core. Takes
//               traps (interrupt, illegal instruction, ecall, ebreak), handles
//               mret, and issues one-cycle PC redirects. A fault raised while
//               already inside the trap handler halts the core until reset.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               dec (slave)    - decoder issue / redirect bundle
//               irq, irq_enable- machine external interrupt and global enable
//               mtvec_we/wdata - trap vector write port
//               mepc, mcause, mtvec - trap CSRs
//               halted         - double fault, core stopped
//               instruction/mtval - only with RV32_TRAP_MTVAL_EN defined
// Options     : RV32_TRAP_MTVAL_EN - adds instruction input and mtval output
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mod_trap_controller #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [1:0]  RESET_PRIV  = 2'b11
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  rv32_mod_trap_controller_if.slave     dec,
  input  wire logic                     irq,
  input  wire logic                     irq_enable,
  input  wire logic                     mtvec_we,
  input  wire logic [31:0]              mtvec_wdata,
`ifdef RV32_TRAP_MTVAL_EN
  input  wire logic [31:0]              instruction,
  output logic [31:0]                   mtval,
`endif
  output logic [31:0]                   mepc,
  output logic [31:0]                   mcause,
  output logic [31:0]                   mtvec,
  output logic                          halted
);

  localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_U = 32'd8;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [1:0]  PRIV_U        = 2'b00;
  localparam logic [1:0]  PRIV_M        = 2'b11;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ENTER  = 2'd1,
    S_RETURN = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  priv_q, mpp_q;
  logic        in_trap_q;
  logic [31:0] mepc_q, mcause_q, mtvec_q, redirect_pc_q;
  logic [31:0] cause_d;
  logic        busy_d;

  // Next-state / cause selection. Priority order matters: a fault inside the
  // handler halts before anything else is considered.
  always_comb begin
    state_d = state_q;
    cause_d = mcause_q;
    busy_d  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (dec.instr_valid) begin
          if ((dec.dec_error || dec.sys_jump_to_m) && in_trap_q) begin
            state_d = S_HALT;
            busy_d  = 1'b1;
          end else if (irq && irq_enable && !in_trap_q) begin
            state_d = S_ENTER;
            cause_d = CAUSE_IRQ;
            busy_d  = 1'b1;
          end else if (dec.dec_error) begin
            state_d = S_ENTER;
            cause_d = CAUSE_ILLEGAL;
            busy_d  = 1'b1;
          end else if (dec.sys_jump_to_m && dec.instr_imm0) begin
            state_d = S_ENTER;
            cause_d = CAUSE_BREAK;
            busy_d  = 1'b1;
          end else if (dec.sys_jump_to_m) begin
            state_d = S_ENTER;
            cause_d = (priv_q == PRIV_U) ? CAUSE_ECALL_U : CAUSE_ECALL_M;
            busy_d  = 1'b1;
          end else if (dec.sys_ret_from_priv) begin
            state_d = S_RETURN;
            busy_d  = 1'b1;
          end
        end
      end
      S_HALT: begin
        busy_d = 1'b1;
      end
      default: begin
        // ENTER / RETURN are single-cycle redirect slots.
        state_d = S_RUN;
        busy_d  = 1'b1;
      end
    endcase
  end

  // state_d can only be ENTER/RETURN when leaving RUN, so those tests double
  // as the "transition taken this edge" condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      priv_q        <= RESET_PRIV;
      mpp_q         <= PRIV_M;
      in_trap_q     <= 1'b0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mtvec_q       <= MTVEC_RESET & ~32'h3;
      redirect_pc_q <= 32'd0;
`ifdef RV32_TRAP_MTVAL_EN
      mtval         <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      if (mtvec_we && (state_q != S_HALT)) begin
        mtvec_q <= mtvec_wdata & ~32'h3;
      end
      if (state_d == S_ENTER) begin
        mepc_q        <= dec.pc & ~32'h1;
        mcause_q      <= cause_d;
        mpp_q         <= priv_q;
        priv_q        <= PRIV_M;
        in_trap_q     <= 1'b1;
        // Old mtvec: a same-cycle write lands after this redirect.
        redirect_pc_q <= mtvec_q;
`ifdef RV32_TRAP_MTVAL_EN
        mtval         <= (cause_d == CAUSE_ILLEGAL) ? instruction : 32'd0;
`endif
      end else if (state_d == S_RETURN) begin
        redirect_pc_q <= mepc_q;
        priv_q        <= mpp_q;
        in_trap_q     <= 1'b0;
        mpp_q         <= PRIV_U;
      end
    end
  end

  assign dec.priviledge      = priv_q;
  assign dec.in_trap_handler = in_trap_q;
  assign dec.busy            = busy_d;
  assign dec.redirect_valid  = (state_q == S_ENTER) || (state_q == S_RETURN);
  assign dec.redirect_pc     = redirect_pc_q;
  assign mepc                = mepc_q;
  assign mcause              = mcause_q;
  assign mtvec               = mtvec_q;
  assign halted              = (state_q == S_HALT);

endmodule
`default_nettype wire
